// File: rtl/wave_meter.sv
// rtl/wave_meter.sv - per-period max/min/peak-to-peak and period meter for a DDS sample stream
module wave_meter #(
    parameter int              DW      = 16,
    parameter int              PW      = 24,
    parameter logic [DW-1:0]   MID     = 16'h8000,
    parameter logic [DW-1:0]   HYST    = 16'h0400,
    parameter logic [PW-1:0]   TIMEOUT = 24'hFFFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] q,
    output logic          meas_valid,
    output logic [PW-1:0] period,
    output logic [DW-1:0] vmax,
    output logic [DW-1:0] vmin,
    output logic [DW-1:0] vpp,
    output logic          no_signal
);

    // One extra bit catches overflow of MID+HYST and borrow of MID-HYST.
    localparam logic [DW:0] HI_SUM = {1'b0, MID} + {1'b0, HYST};
    localparam logic [DW:0] LO_DIF = {1'b0, MID} - {1'b0, HYST};
    localparam logic [DW-1:0] HI_THR = HI_SUM[DW-1:0];
    localparam logic [DW-1:0] LO_THR = LO_DIF[DW-1:0];

    generate
        if (HI_SUM[DW] || LO_DIF[DW]) begin : g_thr_range
            $error("wave_meter: MID +/- HYST outside the sample range");
        end
    endgenerate

    typedef enum logic [1:0] {
        SEEK_LOW,
        SEEK_RISE,
        RUN_HIGH,
        RUN_LOW
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] cnt, cnt_nx;
    logic [PW-1:0] idle_cnt, idle_nx;
    logic [DW-1:0] run_max, run_max_nx;
    logic [DW-1:0] run_min, run_min_nx;
    logic [PW-1:0] period_nx;
    logic [DW-1:0] vmax_nx, vmin_nx, vpp_nx;
    logic          mv_nx, ns_nx;

    logic          lo, hi;
    logic [PW-1:0] cnt_inc, idle_inc;
    logic [DW-1:0] max_upd, min_upd;

    assign lo       = (q < LO_THR);
    assign hi       = (q >= HI_THR);
    assign cnt_inc  = (cnt == {PW{1'b1}}) ? cnt : cnt + PW'(1);
    assign idle_inc = (idle_cnt == {PW{1'b1}}) ? idle_cnt : idle_cnt + PW'(1);
    assign max_upd  = (q > run_max) ? q : run_max;
    assign min_upd  = (q < run_min) ? q : run_min;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idle_nx    = idle_cnt;
        run_max_nx = run_max;
        run_min_nx = run_min;
        period_nx  = period;
        vmax_nx    = vmax;
        vmin_nx    = vmin;
        vpp_nx     = vpp;
        mv_nx      = 1'b0;
        ns_nx      = no_signal;

        if (in_valid) begin
            case (state)
                SEEK_LOW: begin
                    if (lo) begin
                        state_nx = SEEK_RISE;
                        idle_nx  = '0;
                        cnt_nx   = '0;
                    end else if (idle_inc == TIMEOUT) begin
                        ns_nx   = 1'b1;
                        idle_nx = '0;
                    end else begin
                        idle_nx = idle_inc;
                    end
                end
                SEEK_RISE: begin
                    if (hi) begin
                        state_nx   = RUN_HIGH;
                        cnt_nx     = PW'(1);
                        run_max_nx = q;
                        run_min_nx = q;
                    end else if (cnt_inc == TIMEOUT) begin
                        state_nx = SEEK_LOW;
                        cnt_nx   = '0;
                        idle_nx  = '0;
                        ns_nx    = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                RUN_HIGH: begin
                    if (cnt_inc == TIMEOUT) begin
                        state_nx = SEEK_LOW;
                        cnt_nx   = '0;
                        idle_nx  = '0;
                        ns_nx    = 1'b1;
                    end else begin
                        cnt_nx     = cnt_inc;
                        run_max_nx = max_upd;
                        run_min_nx = min_upd;
                        if (lo) state_nx = RUN_LOW;
                    end
                end
                RUN_LOW: begin
                    // The crossing sample closes the old window and opens the next one.
                    if (hi) begin
                        period_nx  = cnt;
                        vmax_nx    = run_max;
                        vmin_nx    = run_min;
                        vpp_nx     = run_max - run_min;
                        mv_nx      = 1'b1;
                        ns_nx      = 1'b0;
                        state_nx   = RUN_HIGH;
                        cnt_nx     = PW'(1);
                        run_max_nx = q;
                        run_min_nx = q;
                    end else if (cnt_inc == TIMEOUT) begin
                        state_nx = SEEK_LOW;
                        cnt_nx   = '0;
                        idle_nx  = '0;
                        ns_nx    = 1'b1;
                    end else begin
                        cnt_nx     = cnt_inc;
                        run_max_nx = max_upd;
                        run_min_nx = min_upd;
                    end
                end
                default: begin
                    state_nx = SEEK_LOW;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEEK_LOW;
            cnt        <= '0;
            idle_cnt   <= '0;
            run_max    <= '0;
            run_min    <= {DW{1'b1}};
            period     <= '0;
            vmax       <= '0;
            vmin       <= '0;
            vpp        <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idle_cnt   <= idle_nx;
            run_max    <= run_max_nx;
            run_min    <= run_min_nx;
            period     <= period_nx;
            vmax       <= vmax_nx;
            vmin       <= vmin_nx;
            vpp        <= vpp_nx;
            meas_valid <= mv_nx;
            no_signal  <= ns_nx;
        end
    end

endmodule

// File: tb/tb_wave_meter.sv
// tb/tb_wave_meter.sv - table-driven and directed checks for wave_meter
module tb_wave_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] q = 16'h0000;
    logic        meas_valid;
    logic [23:0] period;
    logic [15:0] vmax, vmin, vpp;
    logic        no_signal;

    wave_meter #(.DW(16), .PW(24), .MID(16'h8000), .HYST(16'h0400), .TIMEOUT(24'd500)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .q(q),
        .meas_valid(meas_valid), .period(period), .vmax(vmax), .vmin(vmin),
        .vpp(vpp), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rst;
        logic        gap;
        logic [15:0] v;
        int          n;
        int          exp_mv;
        logic [23:0] exp_period;
        logic [15:0] exp_vmax;
        logic [15:0] exp_vmin;
        logic [15:0] exp_vpp;
        logic        exp_ns;
    } seg_t;

    seg_t segs[21];
    int   errors = 0;
    int   checks = 0;
    int   mv_cnt = 0;
    int   last_mv = -1;
    bit   chk_spacing = 1'b0;

    function automatic seg_t mk(input logic rst, input logic [15:0] v, input int n, input int mv,
                                input logic [23:0] p, input logic [15:0] mx, input logic [15:0] mn,
                                input logic [15:0] pp);
        seg_t s;
        s.rst = rst; s.gap = 1'b0; s.v = v; s.n = n; s.exp_mv = mv;
        s.exp_period = p; s.exp_vmax = mx; s.exp_vmin = mn; s.exp_vpp = pp; s.exp_ns = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo_b, input int hi_b);
        checks++;
        if (act < lo_b || act > hi_b) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h..%0h", name, act, lo_b, hi_b);
        end
    endtask

    task automatic step(input logic [15:0] v, input logic vld);
        @(negedge clk);
        q = v;
        in_valid = vld;
        @(posedge clk);
        #1;
        if (meas_valid) begin
            mv_cnt++;
            if (chk_spacing && last_mv >= 0) check("mv_spacing", 64'(cyc - last_mv), 64'd200);
            last_mv = cyc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset_outputs", {23'd0, meas_valid, period, vmax, vmin, vpp, no_signal}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_mv = -1;
    endtask

    function automatic logic [15:0] sine_at(input int i);
        real r;
        int  s;
        r = 16384.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
        s = 32768 + $rtoi($floor(r + 0.5));
        return s[15:0];
    endfunction

    initial begin
        // Square wave: 50 low / 50 high, period 100.
        segs[0]  = mk(1, 16'h0000, 50, 0, 0,   16'h0000, 16'h0000, 16'h0000);
        segs[1]  = mk(0, 16'hFFFF, 50, 0, 0,   16'h0000, 16'h0000, 16'h0000);
        segs[2]  = mk(0, 16'h0000, 50, 0, 0,   16'h0000, 16'h0000, 16'h0000);
        segs[3]  = mk(0, 16'hFFFF, 50, 1, 100, 16'hFFFF, 16'h0000, 16'hFFFF);
        segs[4]  = mk(0, 16'h0000, 50, 0, 100, 16'hFFFF, 16'h0000, 16'hFFFF);
        segs[5]  = mk(0, 16'hFFFF, 50, 1, 100, 16'hFFFF, 16'h0000, 16'hFFFF);
        segs[6]  = mk(0, 16'h0000, 50, 0, 100, 16'hFFFF, 16'h0000, 16'hFFFF);
        segs[7]  = mk(0, 16'hFFFF, 50, 1, 100, 16'hFFFF, 16'h0000, 16'hFFFF);
        // Partial period, then reset: two crossings needed before the next result.
        segs[8]  = mk(0, 16'h0000, 25, 0, 100, 16'hFFFF, 16'h0000, 16'hFFFF);
        segs[9]  = mk(1, 16'h0000, 50, 0, 0,   16'h0000, 16'h0000, 16'h0000);
        segs[10] = mk(0, 16'hFFFF, 50, 0, 0,   16'h0000, 16'h0000, 16'h0000);
        segs[11] = mk(0, 16'h0000, 50, 0, 0,   16'h0000, 16'h0000, 16'h0000);
        segs[12] = mk(0, 16'hFFFF, 50, 1, 100, 16'hFFFF, 16'h0000, 16'hFFFF);
        // Same square wave with in_valid low every other clock.
        for (int i = 0; i < 8; i++) begin
            segs[13 + i] = segs[i];
            segs[13 + i].gap = 1'b1;
        end

        for (int r = 0; r < 21; r++) begin
            if (segs[r].rst) do_reset();
            chk_spacing = segs[r].gap;
            mv_cnt = 0;
            for (int k = 0; k < segs[r].n; k++) begin
                step(segs[r].v, 1'b1);
                if (segs[r].gap) step(~segs[r].v, 1'b0);
            end
            check($sformatf("row%0d_mv", r), 64'(mv_cnt), 64'(segs[r].exp_mv));
            check($sformatf("row%0d_period", r), 64'(period), 64'(segs[r].exp_period));
            check($sformatf("row%0d_vmax", r), 64'(vmax), 64'(segs[r].exp_vmax));
            check($sformatf("row%0d_vmin", r), 64'(vmin), 64'(segs[r].exp_vmin));
            check($sformatf("row%0d_vpp", r), 64'(vpp), 64'(segs[r].exp_vpp));
            check($sformatf("row%0d_ns", r), 64'(no_signal), 64'(segs[r].exp_ns));
        end
        chk_spacing = 1'b0;

        // Lock, then sit inside the hysteresis band until the timeout fires.
        do_reset();
        mv_cnt = 0;
        for (int k = 0; k < 50; k++) step(16'h0000, 1'b1);
        for (int k = 0; k < 50; k++) step(16'hFFFF, 1'b1);
        for (int k = 0; k < 50; k++) step(16'h0000, 1'b1);
        step(16'hFFFF, 1'b1);
        check("lock_mv", 64'(mv_cnt), 64'd1);
        check("lock_period", 64'(period), 64'd100);
        mv_cnt = 0;
        for (int k = 0; k < 498; k++) step((k % 2) ? 16'h7D00 : 16'h8300, 1'b1);
        check("hyst_ns_before", 64'(no_signal), 64'd0);
        step(16'h7D00, 1'b1);
        check("hyst_ns_at", 64'(no_signal), 64'd1);
        for (int k = 0; k < 501; k++) step((k % 2) ? 16'h7D00 : 16'h8300, 1'b1);
        check("hyst_mv", 64'(mv_cnt), 64'd0);
        check("hyst_ns_held", 64'(no_signal), 64'd1);
        check("hyst_period_held", 64'(period), 64'd100);
        check("hyst_vpp_held", 64'(vpp), 64'hFFFF);

        // Crossing on the sample that would also reach TIMEOUT wins.
        step(16'h0000, 1'b1);
        step(16'hFFFF, 1'b1);
        mv_cnt = 0;
        for (int k = 0; k < 498; k++) step(16'h0000, 1'b1);
        step(16'hFFFF, 1'b1);
        check("prio_mv", 64'(mv_cnt), 64'd1);
        check("prio_period", 64'(period), 64'd499);
        check("prio_ns", 64'(no_signal), 64'd0);
        // One sample longer and the timeout fires instead.
        mv_cnt = 0;
        for (int k = 0; k < 498; k++) step(16'h0000, 1'b1);
        check("to_ns_before", 64'(no_signal), 64'd0);
        step(16'h0000, 1'b1);
        check("to_ns_at", 64'(no_signal), 64'd1);
        step(16'hFFFF, 1'b1);
        check("to_mv", 64'(mv_cnt), 64'd0);
        check("to_period_held", 64'(period), 64'd499);

        // Idle timeout while still seeking the first low.
        do_reset();
        for (int k = 0; k < 499; k++) step(16'h8000, 1'b1);
        check("idle_ns_before", 64'(no_signal), 64'd0);
        step(16'h8000, 1'b1);
        check("idle_ns_at", 64'(no_signal), 64'd1);

        // 256-sample sine, +/-4000 about 8000.
        do_reset();
        mv_cnt = 0;
        for (int i = 0; i < 768; i++) step(sine_at(i % 256), 1'b1);
        check("sine_mv", 64'(mv_cnt), 64'd1);
        check("sine_period", 64'(period), 64'd256);
        check_rng("sine_vmax", int'(vmax), 32'hBFFF, 32'hC001);
        check_rng("sine_vmin", int'(vmin), 32'h3FFF, 32'h4001);
        check_rng("sine_vpp", int'(vpp), 32'h7FFE, 32'h8002);

        // Sawtooth 0000..FF00 in steps of 0100.
        do_reset();
        mv_cnt = 0;
        for (int i = 0; i < 768; i++) step(16'((i % 256) * 256), 1'b1);
        check("saw_mv", 64'(mv_cnt), 64'd2);
        check("saw_period", 64'(period), 64'd256);
        check("saw_vmax", 64'(vmax), 64'hFF00);
        check("saw_vmin", 64'(vmin), 64'h0000);
        check("saw_vpp", 64'(vpp), 64'hFF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
